// File: rtl/tw_modmul_stage.sv
// Twiddle modular-multiply stage for the NTT datapath.
// Multiplies each butterfly output by the upper twiddle half of the ROM word,
// modulo the Goldilocks prime p = 2^64 - 2^32 + 1, and emits canonical residues.
// Four register stages: A aligns din to the ROM read latency, B forms the
// 128-bit product, C folds the high words, D finishes the reduction.
// A single stall freezes every register, including valids and the frame counter.

module tw_modmul_stage #(
    parameter int DW        = 64,
    parameter int TW_WIDTH  = 128,
    parameter int FRAME_LEN = 16,
    parameter int FC_WIDTH  = 4
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic [DW-1:0]       din,
    input  logic                din_vld,
    input  logic [TW_WIDTH-1:0] tw_in,
    input  logic                stall,
    output logic [DW-1:0]       dout,
    output logic                dout_vld,
    output logic                frame_done
);

    localparam logic [63:0] P_MOD = 64'hFFFF_FFFF_0000_0001;
    // 2^64 mod p
    localparam logic [63:0] EPS   = 64'h0000_0000_FFFF_FFFF;

    // Low fold: xl - x3, using 2^96 == -1 mod p; a borrow wrapped in 2^64,
    // which is removed by subtracting 2^64 mod p.
    function automatic logic [63:0] fold_lo(input logic [127:0] prod);
        logic [64:0] diff;
        logic [63:0] t0;
        diff = {1'b0, prod[63:0]} - {33'd0, prod[127:96]};
        if (diff[64]) begin
            t0 = diff[63:0] - EPS;
        end else begin
            t0 = diff[63:0];
        end
        return t0;
    endfunction

    // High fold: x2 * 2^64 == x2 * (2^32 - 1) mod p; always fits in 64 bits.
    function automatic logic [63:0] fold_hi(input logic [127:0] prod);
        logic [63:0] x2_ext;
        x2_ext = {32'd0, prod[95:64]};
        return x2_ext * EPS;
    endfunction

    // Final add with carry fold, then one conditional subtract to canonicalise.
    function automatic logic [63:0] canon_sum(input logic [63:0] t0, input logic [63:0] t1);
        logic [64:0] s;
        logic [63:0] r;
        s = {1'b0, t0} + {1'b0, t1};
        if (s[64]) begin
            r = s[63:0] + EPS;
        end else begin
            r = s[63:0];
        end
        if (r >= P_MOD) begin
            r = r - P_MOD;
        end else begin
            r = r;
        end
        return r;
    endfunction

    logic                a_vld_q, a_vld_d;
    logic [DW-1:0]       a_data_q, a_data_d;
    logic                b_vld_q, b_vld_d;
    logic [2*DW-1:0]     b_prod_q, b_prod_d;
    logic                c_vld_q, c_vld_d;
    logic [DW-1:0]       c_t0_q, c_t0_d;
    logic [DW-1:0]       c_t1_q, c_t1_d;
    logic                dout_vld_q, dout_vld_d;
    logic [DW-1:0]       dout_q, dout_d;
    logic                frame_done_q, frame_done_d;
    logic [FC_WIDTH-1:0] fc_q, fc_d;

    // The ROM word's lower half carries data for another consumer.
    logic tw_lo_unused_s;
    assign tw_lo_unused_s = ^tw_in[DW-1:0];

    // Stage A: capture the sample while its twiddle is being read from the ROM.
    always_comb begin
        a_vld_d  = a_vld_q;
        a_data_d = a_data_q;
        if (!stall) begin
            a_vld_d = din_vld;
            if (din_vld) begin
                a_data_d = din;
            end else begin
                a_data_d = a_data_q;
            end
        end else begin
            a_vld_d  = a_vld_q;
            a_data_d = a_data_q;
        end
    end

    // Stage B: ROM data is now valid; form the full 128-bit product.
    always_comb begin
        b_vld_d  = b_vld_q;
        b_prod_d = b_prod_q;
        if (!stall) begin
            b_vld_d = a_vld_q;
            if (a_vld_q) begin
                b_prod_d = {{DW{1'b0}}, a_data_q} * {{DW{1'b0}}, tw_in[TW_WIDTH-1:DW]};
            end else begin
                b_prod_d = b_prod_q;
            end
        end else begin
            b_vld_d  = b_vld_q;
            b_prod_d = b_prod_q;
        end
    end

    // Stage C: fold the upper 64 product bits into two 64-bit partial terms.
    always_comb begin
        c_vld_d = c_vld_q;
        c_t0_d  = c_t0_q;
        c_t1_d  = c_t1_q;
        if (!stall) begin
            c_vld_d = b_vld_q;
            if (b_vld_q) begin
                c_t0_d = fold_lo(b_prod_q);
                c_t1_d = fold_hi(b_prod_q);
            end else begin
                c_t0_d = c_t0_q;
                c_t1_d = c_t1_q;
            end
        end else begin
            c_vld_d = c_vld_q;
        end
    end

    // Stage D: canonical residue into dout, plus frame counting on each output.
    always_comb begin
        dout_vld_d   = dout_vld_q;
        dout_d       = dout_q;
        frame_done_d = frame_done_q;
        fc_d         = fc_q;
        if (!stall) begin
            dout_vld_d = c_vld_q;
            if (c_vld_q) begin
                dout_d = canon_sum(c_t0_q, c_t1_q);
                if (fc_q == FC_WIDTH'(FRAME_LEN - 1)) begin
                    fc_d         = '0;
                    frame_done_d = 1'b1;
                end else begin
                    fc_d         = fc_q + FC_WIDTH'(1);
                    frame_done_d = 1'b0;
                end
            end else begin
                frame_done_d = 1'b0;
            end
        end else begin
            dout_vld_d = dout_vld_q;
        end
    end

    // Pipeline state registers; reset clears every in-flight sample and the counter.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            a_vld_q      <= 1'b0;
            a_data_q     <= '0;
            b_vld_q      <= 1'b0;
            b_prod_q     <= '0;
            c_vld_q      <= 1'b0;
            c_t0_q       <= '0;
            c_t1_q       <= '0;
            dout_vld_q   <= 1'b0;
            dout_q       <= '0;
            frame_done_q <= 1'b0;
            fc_q         <= '0;
        end else begin
            a_vld_q      <= a_vld_d;
            a_data_q     <= a_data_d;
            b_vld_q      <= b_vld_d;
            b_prod_q     <= b_prod_d;
            c_vld_q      <= c_vld_d;
            c_t0_q       <= c_t0_d;
            c_t1_q       <= c_t1_d;
            dout_vld_q   <= dout_vld_d;
            dout_q       <= dout_d;
            frame_done_q <= frame_done_d;
            fc_q         <= fc_d;
        end
    end

    assign dout       = dout_q;
    assign dout_vld   = dout_vld_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tw_modmul_stage.sv
// Bench for tw_modmul_stage: directed operands, streaming frames with a
// mid-stream stall, and a reset with samples in flight. A scoreboard holds
// expected residue, frame_done and arrival cycle for each accepted sample.

module tb_tw_modmul_stage;

    localparam logic [63:0] P = 64'hFFFF_FFFF_0000_0001;

    logic         CLK = 1'b0;
    logic         rst_n;
    logic [63:0]  din;
    logic         din_vld;
    logic [127:0] tw_in;
    logic         stall;
    logic [63:0]  dout;
    logic         dout_vld;
    logic         frame_done;

    always #5 CLK = ~CLK;

    tw_modmul_stage dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .din        (din),
        .din_vld    (din_vld),
        .tw_in      (tw_in),
        .stall      (stall),
        .dout       (dout),
        .dout_vld   (dout_vld),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [63:0] data;
        logic        fd;
        int unsigned icyc;
        int unsigned iscnt;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned scnt     = 0;
    logic        last_stalled = 1'b0;
    logic [63:0] last_dout = 64'd0;
    logic [63:0] cur_tw    = 64'd0;
    int unsigned fcount    = 0;
    logic [63:0] tws [4] = '{64'h1, 64'hFFFF_FFFE_FFFF_FFC1, 64'h1000, 64'hFFFF_FFFE_FFFC_0001};

    // Edge bookkeeping: cycle count, stalled edges, and whether the last edge was frozen.
    always @(posedge CLK) begin
        cyc          <= cyc + 1;
        if (stall) scnt <= scnt + 1;
        last_stalled <= stall;
    end

    function automatic logic [63:0] modmul(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] prod;
        logic [127:0] rem;
        prod = {64'd0, a} * {64'd0, b};
        rem  = prod % {64'd0, P};
        return rem[63:0];
    endfunction

    function automatic logic [63:0] rand_fe();
        logic [63:0] v;
        v = {32'($urandom), 32'($urandom)};
        return v % P;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One input cycle; tw_in mimics a ROM with one-cycle latency frozen by stall.
    task automatic drive(input logic vld, input logic [63:0] d, input logic [63:0] tw, input logic stl);
        exp_t e;
        @(negedge CLK);
        if (!stall) tw_in = {cur_tw, 32'($urandom), 32'($urandom)};
        din     = d;
        din_vld = vld;
        stall   = stl;
        cur_tw  = tw;
        if (vld && !stl) begin
            e.data = modmul(d, tw);
            e.fd   = (fcount == 15);
            fcount = (fcount + 1) % 16;
            e.icyc = cyc;
            e.iscnt = scnt;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        drive(1'b0, rand_fe(), rand_fe(), 1'b0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            idle();
            #1;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_dout"},       dout, 64'd0);
        check({tag, "_dout_vld"},   64'(dout_vld), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        sb.delete();
        fcount    = 0;
        last_dout = 64'd0;
        din_vld   = 1'b0;
        stall     = 1'b0;
        repeat (2) @(negedge CLK);
        #2 rst_n = 1'b1;
    endtask

    // Output monitor: compares each freshly produced output against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (rst_n && !last_stalled) begin
                if (dout_vld) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 64'(dout_vld), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("dout", dout, e.data);
                        check("frame_done", 64'(frame_done), 64'(e.fd));
                        check("arrival_cycle", 64'(cyc), 64'(e.icyc + 4 + (scnt - e.iscnt)));
                        last_dout = e.data;
                    end
                end else begin
                    check("idle_frame_done", 64'(frame_done), 64'd0);
                    check("idle_dout_hold", dout, last_dout);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] d;
        rst_n   = 1'b0;
        din     = 64'd0;
        din_vld = 1'b0;
        tw_in   = 128'd0;
        stall   = 1'b0;
        #1;
        check("reset_dout",       dout, 64'd0);
        check("reset_dout_vld",   64'(dout_vld), 64'd0);
        check("reset_frame_done", 64'(frame_done), 64'd0);
        repeat (2) @(negedge CLK);
        #2 rst_n = 1'b1;

        // Directed operands
        drive(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1, 1'b0);
        repeat (5) idle();
        drive(1'b1, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 1'b0);
        drive(1'b1, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b0);
        drive(1'b1, 64'd0, rand_fe(), 1'b0);
        drive(1'b1, 64'hFFFF_FFFF_0000_0000, 64'h1, 1'b0);
        drain("drain_directed");
        check("max_operands_value", modmul(64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000), 64'd1);

        // Align the frame counter, then a full 16-sample frame
        @(negedge CLK);
        do_reset("reset_pulse");
        for (int i = 0; i < 16; i++) drive(1'b1, rand_fe(), tws[i % 4], 1'b0);
        drain("drain_frame1");

        // Second frame with a 3-cycle stall mid-stream; counter must restart
        for (int i = 0; i < 16; i++) begin
            d = rand_fe();
            if (i == 6) repeat (3) drive(1'b1, d, tws[i % 4], 1'b1);
            drive(1'b1, d, tws[i % 4], 1'b0);
        end
        drain("drain_frame2");

        // Reset with counter at 9 and 3 samples in flight
        for (int i = 0; i < 12; i++) drive(1'b1, rand_fe(), tws[i % 4], 1'b0);
        idle();
        #1;
        check("inflight_before_reset", 64'(sb.size()), 64'd3);
        do_reset("reset_mid");
        for (int i = 0; i < 16; i++) drive(1'b1, rand_fe(), tws[i % 4], 1'b0);
        drain("drain_after_reset");
        repeat (3) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tw_modmul_stage.md
Name: tw_modmul_stage

Overview:
- Downstream consumer of the twiddle ROM.
- Multiplies each 64-bit butterfly output by the upper 64-bit twiddle half of the ROM word, modulo the Goldilocks prime p = 2^64 - 2^32 + 1.
- Produces canonical residues for the next radix stage.
- Aligns data to the ROM's one-cycle read latency, is fully pipelined with stall, and flags frame completion.

Parameters:
- DW, 64, data/residue width
- TW_WIDTH, 128, ROM word width; twiddle = bits [TW_WIDTH-1:DW]
- FRAME_LEN, 16, outputs per frame before frame_done pulses
- FC_WIDTH, 4, frame counter width, ceil(log2(FRAME_LEN))

Ports:
- CLK  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- din  input  DW  butterfly output; must be < p
- din_vld  input  1  din valid; the twiddle for this sample is read in the same cycle (ROM CEN low)
- tw_in  input  TW_WIDTH  ROM Q; valid one cycle after din_vld
- stall  input  1  freeze entire pipeline
- dout  output  DW  (din*tw) mod p, canonical
- dout_vld  output  1  dout valid
- frame_done  output  1  one-cycle pulse with the FRAME_LEN-th dout_vld of a frame

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock CLK.
- Reset values: dout=0, dout_vld=0, frame_done=0, all pipeline valids=0, frame counter=0.
- Every register holds its value while stall=1, including valids, data and counter. tw_in is sampled only when stall=0. The ROM must be frozen by the same stall.
- Stage A (align): register din and din_vld.
- Stage B: sample tw_in[127:64] and stage-A data. Form the full 128-bit product P.
- Stage C: split P = x3*2^96 + x2*2^64 + xl, where x3 = P[127:96], x2 = P[95:64], xl = P[63:0].
  - t0 = xl - x3 (64-bit). On borrow, t0 = t0 - (2^32-1) mod 2^64.
  - t1 = x2*(2^32-1), zero-extended to 64 bits.
- Stage D: r = t0 + t1 (65-bit).
  - On carry, r = r[63:0] + (2^32-1).
  - If the result >= p, subtract p.
  - Register into dout.
- Latency: dout_vld rises exactly 4 un-stalled cycles after din_vld. Throughput is one sample per cycle. Bubbles propagate unchanged.
- dout updates only when its stage valid is 1. On bubbles dout holds its last value while dout_vld=0.
- Frame counter: increments on each dout_vld. When the counter equals FRAME_LEN-1 and dout_vld=1, frame_done=1 and the counter wraps to 0.
- Reset mid-frame clears the counter and all in-flight samples. No partial output after reset release.
- Non-canonical din (>= p) is outside the contract. The output is then unspecified but must still be < 2^64 with no X.
- No combinational path from any input to any output.

Test Plan:
- Identity: din=0x123456789ABCDEF0, tw_in=128'h0000000000000001_xxxxxxxxxxxxxxxx one cycle later -> dout=0x123456789ABCDEF0, dout_vld exactly 4 cycles after din_vld.
- Reduction: din=0x0000000100000000, tw upper=0x0000000100000000 -> dout=0x00000000FFFFFFFF.
- Max operands: din=0xFFFFFFFF00000000 (p-1), tw upper=0xFFFFFFFF00000000 -> dout=0x0000000000000001. Zero operand din=0 with any twiddle -> dout=0.
- Streaming frame: 16 consecutive din_vld with ROM stage-0 twiddles cycling 1, 0xfffffffeffffffc1, 0x1000, 0xfffffffefffc0001 -> 16 back-to-back dout_vld matching a software golden model. frame_done pulses on the 16th only. The counter then restarts.
- Stall: assert stall for 3 cycles mid-stream -> outputs, order and count are unchanged; dout_vld is delayed by exactly 3 cycles. No sample is duplicated or dropped.
- Reset mid-operation: pull rst_n low with 3 samples in flight and the counter at 9 -> all outputs are 0 immediately and asynchronously. After release a fresh 16-sample frame yields frame_done on its 16th output.
